// File: rtl/trail_writer.sv
// Trail writer: turns (x, y, color) point requests into 2-pixel frame-buffer word writes
// through a small request FIFO, and sweeps the whole frame with the background color on request.
module trail_writer #(
  parameter int         H_WORDS    = 320,
  parameter int         V_LINES    = 480,
  parameter logic [3:0] BG_COLOR   = 4'h8,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clear_req,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [9:0]  pt_x,
  input  logic [9:0]  pt_y,
  input  logic [3:0]  pt_color,
  output logic        WE,
  output logic [18:0] write_address,
  output logic [15:0] Data_In,
  output logic        busy_clear,
  output logic [7:0]  drop_count
);

  localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [18:0] LAST_ADDR = 19'(H_WORDS * V_LINES - 1);
  localparam logic [15:0] BG_WORD   = {4'h0, BG_COLOR, 4'h0, BG_COLOR};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [22:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [18:0]       addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic [7:0]        drop_q, drop_d;

  logic              accept, in_range, push, pop, flush, idle_step;
  logic [18:0]       pt_addr;
  logic [22:0]       head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign pt_ready = (count_q != CNT_W'(FIFO_DEPTH));

  always_comb begin
    accept    = pt_valid && pt_ready;
    in_range  = (32'(pt_x) < 2 * H_WORDS) && (32'(pt_y) < V_LINES);
    pt_addr   = 19'(pt_y) * 19'(H_WORDS) + 19'(pt_x[9:1]);
    head      = mem_q[rd_ptr_q];

    state_d   = state_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = busy_q;
    drop_d    = drop_q;
    push      = accept && in_range;
    pop       = 1'b0;
    flush     = 1'b0;
    idle_step = 1'b0;

    if (accept && !in_range && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          flush   = 1'b1;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = BG_WORD;
          busy_d  = 1'b1;
        end else begin
          idle_step = 1'b1;
        end
      end
      CLEAR: begin
        // The final sweep edge already behaves as IDLE so queued points follow with no gap.
        if (addr_q == LAST_ADDR) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          idle_step = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + 19'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (idle_step && count_q != '0) begin
      pop    = 1'b1;
      we_d   = 1'b1;
      addr_d = head[22:4];
      data_d = {4'h0, head[3:0], 4'h0, head[3:0]};
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge Clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {pt_addr, pt_color};
  end

  assign WE            = we_q;
  assign write_address = addr_q;
  assign Data_In       = data_q;
  assign busy_clear    = busy_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_trail_writer.sv
// Directed bench for trail_writer; frame height is reduced to keep clear sweeps short.
module tb_trail_writer;

  localparam int H     = 320;
  localparam int V     = 24;
  localparam int TOTAL = H * V;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        clear_req;
  logic        pt_valid;
  logic        pt_ready;
  logic [9:0]  pt_x;
  logic [9:0]  pt_y;
  logic [3:0]  pt_color;
  logic        WE;
  logic [18:0] write_address;
  logic [15:0] Data_In;
  logic        busy_clear;
  logic [7:0]  drop_count;

  int n_vec = 0;
  int n_err = 0;

  trail_writer #(.H_WORDS(H), .V_LINES(V), .BG_COLOR(4'h8), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .clear_req(clear_req), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_color(pt_color), .WE(WE), .write_address(write_address),
    .Data_In(Data_In), .busy_clear(busy_clear), .drop_count(drop_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; clear_req = 1'b0; pt_valid = 1'b0; pt_x = '0; pt_y = '0; pt_color = '0;
    #13;
    n_vec++; if (WE !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", WE); end
    n_vec++; if (write_address !== 19'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", write_address); end
    n_vec++; if (Data_In !== 16'h0) begin n_err++; $display("FAIL reset_data got %h want 0000", Data_In); end
    n_vec++; if (busy_clear !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_clear); end
    n_vec++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    tick();
    Reset = 1'b0;
    tick();
    n_vec++; if (pt_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", pt_ready); end
  endtask

  task automatic test_single_point();
    pt_valid = 1'b1; pt_x = 10'd101; pt_y = 10'd2; pt_color = 4'd3;
    tick();
    pt_valid = 1'b0;
    n_vec++; if (WE !== 1'b0) begin n_err++; $display("FAIL single_early_we got %b want 0", WE); end
    tick();
    n_vec++; if (WE !== 1'b1) begin n_err++; $display("FAIL single_we got %b want 1", WE); end
    n_vec++; if (write_address !== 19'd690) begin n_err++; $display("FAIL single_addr got %0d want 690", write_address); end
    n_vec++; if (Data_In !== 16'h0303) begin n_err++; $display("FAIL single_data got %h want 0303", Data_In); end
    tick();
    n_vec++; if (WE !== 1'b0) begin n_err++; $display("FAIL single_we_off got %b want 0", WE); end
    n_vec++; if (write_address !== 19'd690) begin n_err++; $display("FAIL single_addr_hold got %0d want 690", write_address); end
    n_vec++; if (Data_In !== 16'h0303) begin n_err++; $display("FAIL single_data_hold got %h want 0303", Data_In); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  xs [3]  = '{10'd4, 10'd5, 10'd639};
    logic [3:0]  cs [3]  = '{4'h1, 4'h2, 4'hF};
    logic [18:0] ea [3]  = '{19'd2, 19'd2, 19'd319};
    logic [15:0] ed [3]  = '{16'h0101, 16'h0202, 16'h0F0F};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin pt_valid = 1'b1; pt_x = xs[i]; pt_y = 10'd0; pt_color = cs[i]; end
      else pt_valid = 1'b0;
      tick();
      if (i == 0) begin
        n_vec++; if (WE !== 1'b0) begin n_err++; $display("FAIL b2b_first_we got %b want 0", WE); end
      end else begin
        n_vec++;
        if (WE !== 1'b1 || write_address !== ea[i-1] || Data_In !== ed[i-1]) begin
          n_err++;
          $display("FAIL b2b_write%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   i-1, WE, write_address, Data_In, ea[i-1], ed[i-1]);
        end
      end
    end
    tick();
    n_vec++; if (WE !== 1'b0) begin n_err++; $display("FAIL b2b_end_we got %b want 0", WE); end
  endtask

  task automatic test_full_clear();
    int bad = 0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      if (WE !== 1'b1 || write_address !== 19'(i) || Data_In !== 16'h0808 || busy_clear !== 1'b1) bad++;
      clear_req = (i == 100);
      tick();
    end
    clear_req = 1'b0;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL clear_sweep got %0d bad cycles want 0", bad); end
    n_vec++; if (busy_clear !== 1'b0) begin n_err++; $display("FAIL clear_busy_end got %b want 0", busy_clear); end
    n_vec++; if (WE !== 1'b0) begin n_err++; $display("FAIL clear_we_end got %b want 0", WE); end
    n_vec++; if (write_address !== 19'(TOTAL-1)) begin n_err++; $display("FAIL clear_addr_hold got %0d want %0d", write_address, TOTAL-1); end
  endtask

  task automatic test_backpressure_clear();
    logic [9:0]  px [5] = '{10'd0, 10'd639, 10'd200, 10'd7, 10'd2};
    logic [9:0]  py [5] = '{10'd0, 10'd23, 10'd10, 10'd1, 10'd2};
    logic [3:0]  pc [5] = '{4'h1, 4'h2, 4'h4, 4'h6, 4'h7};
    logic [18:0] ea [4] = '{19'd0, 19'd7679, 19'd3300, 19'd323};
    int bad = 0;
    int rbad = 0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      if (WE !== 1'b1 || write_address !== 19'(i) || Data_In !== 16'h0808) bad++;
      if (i >= 10 && i < 20) begin
        pt_valid = 1'b1;
        pt_x = px[(i < 14) ? i-10 : 4]; pt_y = py[(i < 14) ? i-10 : 4]; pt_color = pc[(i < 14) ? i-10 : 4];
      end else pt_valid = 1'b0;
      if (pt_ready !== (i < 14)) rbad++;
      tick();
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_sweep got %0d bad cycles want 0", bad); end
    n_vec++; if (rbad != 0) begin n_err++; $display("FAIL bp_ready got %0d bad cycles want 0", rbad); end
    n_vec++; if (busy_clear !== 1'b0) begin n_err++; $display("FAIL bp_busy_end got %b want 0", busy_clear); end
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if (WE !== 1'b1 || write_address !== ea[j] || Data_In !== {4'h0, pc[j], 4'h0, pc[j]}) begin
        n_err++;
        $display("FAIL bp_write%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 j, WE, write_address, Data_In, ea[j], {4'h0, pc[j], 4'h0, pc[j]});
      end
      tick();
    end
    n_vec++; if (WE !== 1'b0) begin n_err++; $display("FAIL bp_after_we got %b want 0", WE); end
  endtask

  task automatic test_range_drop();
    int webad = 0;
    pt_valid = 1'b1; pt_x = 10'd640; pt_y = 10'd0; pt_color = 4'h5;
    tick();
    pt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (WE !== 1'b0) webad++;
      tick();
    end
    n_vec++; if (webad != 0) begin n_err++; $display("FAIL drop_no_we got %0d we cycles want 0", webad); end
    n_vec++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL drop_one got %0d want 1", drop_count); end
    webad = 0;
    for (int i = 0; i < 300; i++) begin
      pt_valid = 1'b1;
      pt_x = (i % 2 == 0) ? 10'(640 + i) : 10'd5;
      pt_y = (i % 2 == 0) ? 10'd3 : 10'(V + i);
      tick();
      if (WE !== 1'b0) webad++;
    end
    pt_valid = 1'b0;
    tick();
    n_vec++; if (webad != 0) begin n_err++; $display("FAIL drop_many_no_we got %0d we cycles want 0", webad); end
    n_vec++; if (drop_count !== 8'd255) begin n_err++; $display("FAIL drop_saturate got %0d want 255", drop_count); end
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    n_vec++; if (write_address !== 19'd1000) begin n_err++; $display("FAIL rmc_reach got %0d want 1000", write_address); end
    #2 Reset = 1'b1;
    #1;
    n_vec++; if (WE !== 1'b0) begin n_err++; $display("FAIL rmc_we got %b want 0", WE); end
    n_vec++; if (busy_clear !== 1'b0) begin n_err++; $display("FAIL rmc_busy got %b want 0", busy_clear); end
    n_vec++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL rmc_drop got %0d want 0", drop_count); end
    tick();
    tick();
    Reset = 1'b0;
    tick();
    n_vec++; if (WE !== 1'b0 || busy_clear !== 1'b0) begin n_err++; $display("FAIL rmc_no_resume got we=%b busy=%b want 0 0", WE, busy_clear); end
    pt_valid = 1'b1; pt_x = 10'd0; pt_y = 10'd0; pt_color = 4'h5;
    tick();
    pt_valid = 1'b0;
    tick();
    n_vec++;
    if (WE !== 1'b1 || write_address !== 19'd0 || Data_In !== 16'h0505) begin
      n_err++;
      $display("FAIL rmc_point got we=%b addr=%0d data=%h want we=1 addr=0 data=0505", WE, write_address, Data_In);
    end
  endtask

  task automatic test_collision();
    int seen = 0;
    int webad = 0;
    tick();
    pt_valid = 1'b1; pt_x = 10'd10; pt_y = 10'd3; pt_color = 4'h9;
    clear_req = 1'b1;
    tick();
    pt_valid = 1'b0; clear_req = 1'b0;
    n_vec++; if (busy_clear !== 1'b1) begin n_err++; $display("FAIL coll_busy got %b want 1", busy_clear); end
    for (int i = 0; i < TOTAL + 5; i++) begin
      if (WE === 1'b1 && Data_In === 16'h0909) seen++;
      if (i >= TOTAL && WE !== 1'b0) webad++;
      tick();
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL coll_written got %0d writes want 0", seen); end
    n_vec++; if (webad != 0) begin n_err++; $display("FAIL coll_post_we got %0d we cycles want 0", webad); end
    n_vec++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL coll_drop got %0d want 0", drop_count); end
    n_vec++; if (pt_ready !== 1'b1) begin n_err++; $display("FAIL coll_ready got %b want 1", pt_ready); end
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_back_to_back();
    test_full_clear();
    test_backpressure_clear();
    test_range_drop();
    test_reset_mid_clear();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
